// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: merges pipeline write-back with a one-entry
// long-latency-unit buffer. Optional perf counters via RF_WB_ARBITER_PERF_EN.
module rf_wb_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_valid,
    input  logic [37:0] wb_bus,
    output logic        wb_ready,
    input  logic        lu_valid,
    input  logic [37:0] lu_bus,
    output logic        lu_ready,
    output logic [37:0] rf_bus,
    output logic [1:0]  state_o
`ifdef RF_WB_ARBITER_PERF_EN
    ,
    output logic [31:0] perf_wb_stall,
    output logic [31:0] perf_lu_drop
`endif
);

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] HELD  = 2'd1;
    localparam logic [1:0] FORCE = 2'd2;

    // Handshake: a request transfers in any cycle where valid && ready are both
    // high at posedge clk; ready never depends on the same-cycle valid input.

    logic [1:0]  state_q, state_d;
    logic [37:0] hold_q, hold_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [37:0] rf_q, rf_d;
    logic        wb_grant;
    logic        waw;

    // Writes to r0 are squashed by clearing we; address and data still propagate.
    function automatic logic [37:0] gate_r0(input logic [37:0] b);
        return {b[37] && (b[36:32] != 5'd0), b[36:0]};
    endfunction

    assign wb_ready = (state_q != FORCE);
    assign lu_ready = (state_q == EMPTY);
    assign wb_grant = wb_valid && wb_ready;
    assign waw      = (state_q == HELD) && wb_grant && wb_bus[37] &&
                      (wb_bus[36:32] == hold_q[36:32]) && (hold_q[36:32] != 5'd0);
    assign rf_bus   = rf_q;
    assign state_o  = state_q;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        cnt_d   = cnt_q;
        rf_d    = {1'b0, rf_q[36:0]};
        case (state_q)
            EMPTY: begin
                if (wb_grant) rf_d = gate_r0(wb_bus);
                if (lu_valid) begin
                    hold_d  = lu_bus;
                    state_d = HELD;
                    cnt_d   = 3'd0;
                end
            end
            HELD: begin
                if (!wb_valid) begin
                    rf_d    = gate_r0(hold_q);
                    state_d = EMPTY;
                    cnt_d   = 3'd0;
                end else begin
                    rf_d = gate_r0(wb_bus);
                    if (waw) begin
                        state_d = EMPTY;
                        cnt_d   = 3'd0;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                        if (cnt_q == 3'(STARVE_MAX - 1)) state_d = FORCE;
                    end
                end
            end
            FORCE: begin
                rf_d    = gate_r0(hold_q);
                state_d = EMPTY;
                cnt_d   = 3'd0;
            end
            default: begin
                state_d = EMPTY;
                cnt_d   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= EMPTY;
            hold_q  <= 38'd0;
            cnt_q   <= 3'd0;
            rf_q    <= 38'd0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
            rf_q    <= rf_d;
        end
    end

`ifdef RF_WB_ARBITER_PERF_EN
    logic [31:0] stall_q, drop_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_q <= 32'd0;
            drop_q  <= 32'd0;
        end else begin
            if (wb_valid && !wb_ready && (stall_q != 32'hFFFF_FFFF)) stall_q <= stall_q + 32'd1;
            if (waw && (drop_q != 32'hFFFF_FFFF)) drop_q <= drop_q + 32'd1;
        end
    end

    assign perf_wb_stall = stall_q;
    assign perf_lu_drop  = drop_q;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter (default STARVE_MAX=4).
module tb_rf_wb_arbiter;

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] HELD  = 2'd1;
  localparam logic [1:0] FORCE = 2'd2;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_valid;
  logic [37:0] wb_bus;
  logic        wb_ready;
  logic        lu_valid;
  logic [37:0] lu_bus;
  logic        lu_ready;
  logic [37:0] rf_bus;
  logic [1:0]  state_o;
`ifdef RF_WB_ARBITER_PERF_EN
  logic [31:0] perf_wb_stall;
  logic [31:0] perf_lu_drop;
`endif

  logic [37:0] exp_q[$];
  logic [37:0] exp_v;
  int checks = 0;
  int errors = 0;

  rf_wb_arbiter dut (
    .clk(clk), .reset(reset),
    .wb_valid(wb_valid), .wb_bus(wb_bus), .wb_ready(wb_ready),
    .lu_valid(lu_valid), .lu_bus(lu_bus), .lu_ready(lu_ready),
    .rf_bus(rf_bus), .state_o(state_o)
`ifdef RF_WB_ARBITER_PERF_EN
    , .perf_wb_stall(perf_wb_stall), .perf_lu_drop(perf_lu_drop)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; wb_valid = 1'b0; wb_bus = '0; lu_valid = 1'b0; lu_bus = '0;
    tick(); tick();
    checks++;
    if (rf_bus !== 38'd0) begin errors++; $display("FAIL reset_rf got %h exp 0", rf_bus); end
    checks++;
    if (state_o !== EMPTY) begin errors++; $display("FAIL reset_state got %0d exp 0", state_o); end
    reset = 1'b1;
    checks++;
    if (lu_ready !== 1'b1 || wb_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready got lu=%b wb=%b exp 1 1", lu_ready, wb_ready);
    end
  endtask

  task automatic test_wb_only();
    wb_valid = 1'b1; wb_bus = {1'b1, 5'd3, 32'h1234};
    checks++;
    if (wb_ready !== 1'b1) begin errors++; $display("FAIL wb_only_ready got %b exp 1", wb_ready); end
    exp_q.push_back({1'b1, 5'd3, 32'h1234});
    tick();
    wb_valid = 1'b0;
    exp_v = exp_q.pop_front(); checks++;
    if (rf_bus !== exp_v) begin errors++; $display("FAIL wb_only_rf got %h exp %h", rf_bus, exp_v); end
    exp_q.push_back({1'b0, 5'd3, 32'h1234});
    tick();
    exp_v = exp_q.pop_front(); checks++;
    if (rf_bus !== exp_v) begin errors++; $display("FAIL idle_hold got %h exp %h", rf_bus, exp_v); end
  endtask

  task automatic test_lu_idle();
    lu_valid = 1'b1; lu_bus = {1'b1, 5'd7, 32'hAA};
    checks++;
    if (lu_ready !== 1'b1) begin errors++; $display("FAIL lu_ready_empty got %b exp 1", lu_ready); end
    exp_q.push_back({1'b0, 5'd3, 32'h1234});
    tick();
    lu_valid = 1'b0;
    exp_v = exp_q.pop_front(); checks++;
    if (rf_bus !== exp_v) begin errors++; $display("FAIL lu_capture_rf got %h exp %h", rf_bus, exp_v); end
    checks++;
    if (state_o !== HELD || lu_ready !== 1'b0) begin
      errors++; $display("FAIL lu_held got state=%0d lu_ready=%b exp 1 0", state_o, lu_ready);
    end
    exp_q.push_back({1'b1, 5'd7, 32'hAA});
    tick();
    exp_v = exp_q.pop_front(); checks++;
    if (rf_bus !== exp_v) begin errors++; $display("FAIL lu_write got %h exp %h", rf_bus, exp_v); end
    checks++;
    if (state_o !== EMPTY || lu_ready !== 1'b1) begin
      errors++; $display("FAIL lu_release got state=%0d lu_ready=%b exp 0 1", state_o, lu_ready);
    end
  endtask

  task automatic test_starve();
    lu_valid = 1'b1; lu_bus = {1'b1, 5'd5, 32'hBEEF};
    exp_q.push_back({1'b0, 5'd7, 32'hAA});
    tick();
    lu_valid = 1'b0;
    exp_v = exp_q.pop_front(); checks++;
    if (rf_bus !== exp_v) begin errors++; $display("FAIL starve_load got %h exp %h", rf_bus, exp_v); end
    wb_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wb_bus = {1'b1, 5'(10 + i), 32'(i)};
      checks++;
      if (wb_ready !== 1'b1) begin errors++; $display("FAIL starve_wb_ready[%0d] got %b exp 1", i, wb_ready); end
      exp_q.push_back({1'b1, 5'(10 + i), 32'(i)});
      tick();
      exp_v = exp_q.pop_front(); checks++;
      if (rf_bus !== exp_v) begin errors++; $display("FAIL starve_wb[%0d] got %h exp %h", i, rf_bus, exp_v); end
    end
    wb_bus = {1'b1, 5'd14, 32'd4};
    checks++;
    if (state_o !== FORCE || wb_ready !== 1'b0) begin
      errors++; $display("FAIL starve_force got state=%0d wb_ready=%b exp 2 0", state_o, wb_ready);
    end
    exp_q.push_back({1'b1, 5'd5, 32'hBEEF});
    tick();
    exp_v = exp_q.pop_front(); checks++;
    if (rf_bus !== exp_v) begin errors++; $display("FAIL starve_lu got %h exp %h", rf_bus, exp_v); end
    checks++;
    if (state_o !== EMPTY || wb_ready !== 1'b1) begin
      errors++; $display("FAIL starve_exit got state=%0d wb_ready=%b exp 0 1", state_o, wb_ready);
    end
    exp_q.push_back({1'b1, 5'd14, 32'd4});
    tick();
    wb_valid = 1'b0;
    exp_v = exp_q.pop_front(); checks++;
    if (rf_bus !== exp_v) begin errors++; $display("FAIL starve_retry got %h exp %h", rf_bus, exp_v); end
`ifdef RF_WB_ARBITER_PERF_EN
    checks++;
    if (perf_wb_stall !== 32'd1) begin errors++; $display("FAIL perf_stall got %0d exp 1", perf_wb_stall); end
`endif
  endtask

  task automatic test_waw();
    lu_valid = 1'b1; lu_bus = {1'b1, 5'd9, 32'h1};
    exp_q.push_back({1'b0, 5'd14, 32'd4});
    tick();
    lu_valid = 1'b0;
    exp_v = exp_q.pop_front(); checks++;
    if (rf_bus !== exp_v) begin errors++; $display("FAIL waw_load got %h exp %h", rf_bus, exp_v); end
    wb_valid = 1'b1; wb_bus = {1'b1, 5'd9, 32'h2};
    exp_q.push_back({1'b1, 5'd9, 32'h2});
    tick();
    wb_valid = 1'b0;
    exp_v = exp_q.pop_front(); checks++;
    if (rf_bus !== exp_v) begin errors++; $display("FAIL waw_wb got %h exp %h", rf_bus, exp_v); end
    checks++;
    if (state_o !== EMPTY) begin errors++; $display("FAIL waw_state got %0d exp 0", state_o); end
    exp_q.push_back({1'b0, 5'd9, 32'h2});
    tick();
    exp_v = exp_q.pop_front(); checks++;
    if (rf_bus !== exp_v) begin errors++; $display("FAIL waw_no_lu got %h exp %h", rf_bus, exp_v); end
`ifdef RF_WB_ARBITER_PERF_EN
    checks++;
    if (perf_lu_drop !== 32'd1) begin errors++; $display("FAIL perf_drop got %0d exp 1", perf_lu_drop); end
`endif
  endtask

  // Held r0 entry: same-address WB must not discard it, and both writes lose we.
  task automatic test_r0();
    wb_valid = 1'b1; wb_bus = {1'b1, 5'd0, 32'hFF};
    exp_q.push_back({1'b0, 5'd0, 32'hFF});
    tick();
    wb_valid = 1'b0;
    exp_v = exp_q.pop_front(); checks++;
    if (rf_bus !== exp_v) begin errors++; $display("FAIL r0_wb got %h exp %h", rf_bus, exp_v); end
    lu_valid = 1'b1; lu_bus = {1'b1, 5'd0, 32'h55};
    exp_q.push_back({1'b0, 5'd0, 32'hFF});
    tick();
    lu_valid = 1'b0;
    exp_v = exp_q.pop_front(); checks++;
    if (rf_bus !== exp_v) begin errors++; $display("FAIL r0_load got %h exp %h", rf_bus, exp_v); end
    wb_valid = 1'b1; wb_bus = {1'b1, 5'd0, 32'h66};
    exp_q.push_back({1'b0, 5'd0, 32'h66});
    tick();
    wb_valid = 1'b0;
    exp_v = exp_q.pop_front(); checks++;
    if (rf_bus !== exp_v) begin errors++; $display("FAIL r0_wb_held got %h exp %h", rf_bus, exp_v); end
    checks++;
    if (state_o !== HELD) begin errors++; $display("FAIL r0_keep_held got %0d exp 1", state_o); end
    exp_q.push_back({1'b0, 5'd0, 32'h55});
    tick();
    exp_v = exp_q.pop_front(); checks++;
    if (rf_bus !== exp_v) begin errors++; $display("FAIL r0_lu got %h exp %h", rf_bus, exp_v); end
  endtask

  task automatic test_lu_ignored();
    lu_valid = 1'b1; lu_bus = {1'b1, 5'd6, 32'h11};
    exp_q.push_back({1'b0, 5'd0, 32'h55});
    tick();
    lu_bus = {1'b1, 5'd8, 32'h22};
    exp_v = exp_q.pop_front(); checks++;
    if (rf_bus !== exp_v) begin errors++; $display("FAIL ign_load got %h exp %h", rf_bus, exp_v); end
    exp_q.push_back({1'b1, 5'd6, 32'h11});
    tick();
    lu_valid = 1'b0;
    exp_v = exp_q.pop_front(); checks++;
    if (rf_bus !== exp_v) begin errors++; $display("FAIL ign_first got %h exp %h", rf_bus, exp_v); end
    exp_q.push_back({1'b0, 5'd6, 32'h11});
    tick();
    exp_v = exp_q.pop_front(); checks++;
    if (rf_bus !== exp_v || state_o !== EMPTY) begin
      errors++; $display("FAIL ign_second got %h st=%0d exp %h st=0", rf_bus, state_o, exp_v);
    end
  endtask

  task automatic test_random_wb();
    logic [4:0]  a;
    logic [31:0] d;
    logic        w;
    for (int i = 0; i < 8; i++) begin
      a = 5'($urandom_range(0, 31)); d = $urandom; w = 1'($urandom_range(0, 1));
      wb_valid = 1'b1; wb_bus = {w, a, d};
      exp_q.push_back({w && (a != 5'd0), a, d});
      tick();
      exp_v = exp_q.pop_front(); checks++;
      if (rf_bus !== exp_v) begin errors++; $display("FAIL rand_wb[%0d] got %h exp %h", i, rf_bus, exp_v); end
    end
    wb_valid = 1'b0;
    exp_q.push_back({1'b0, exp_v[36:0]});
    tick();
    exp_v = exp_q.pop_front(); checks++;
    if (rf_bus !== exp_v) begin errors++; $display("FAIL rand_idle got %h exp %h", rf_bus, exp_v); end
  endtask

  task automatic test_reset_held();
    lu_valid = 1'b1; lu_bus = {1'b1, 5'd4, 32'h77};
    tick();
    lu_valid = 1'b0;
    checks++;
    if (state_o !== HELD) begin errors++; $display("FAIL rh_held got %0d exp 1", state_o); end
    reset = 1'b0;
    tick();
    checks++;
    if (state_o !== EMPTY || rf_bus !== 38'd0 || lu_ready !== 1'b1) begin
      errors++; $display("FAIL rh_reset got st=%0d rf=%h lu=%b exp 0 0 1", state_o, rf_bus, lu_ready);
    end
    reset = 1'b1;
    exp_q.push_back(38'd0);
    tick();
    exp_v = exp_q.pop_front(); checks++;
    if (rf_bus !== exp_v || state_o !== EMPTY) begin
      errors++; $display("FAIL rh_lost got rf=%h st=%0d exp %h st=0", rf_bus, state_o, exp_v);
    end
  endtask

  initial begin
    test_reset();
    test_wb_only();
    test_lu_idle();
    test_starve();
    test_waw();
    test_r0();
    test_lu_ignored();
    test_random_wb();
    test_reset_held();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain got %0d exp 0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4, range 1-7: consecutive denied cycles before a held LU entry is forced through.
REQ-002 clk  input  1  clock; all state updates on posedge clk.
REQ-003 reset  input  1  synchronous, active-low reset.
REQ-004 wb_valid  input  1  pipeline write-back request valid.
REQ-005 wb_bus  input  38  {we[37], waddr[36:32], wdata[31:0]} from pipeline write-back.
REQ-006 wb_ready  output  1  pipeline request accepted this cycle; combinational.
REQ-007 lu_valid  input  1  long-latency unit (mul/div) result valid.
REQ-008 lu_bus  input  38  {we, waddr, wdata}, same packing as wb_bus.
REQ-009 lu_ready  output  1  high when the LU holding buffer is empty; combinational from state only.
REQ-010 rf_bus  output  38  registered {we, waddr, wdata} to the register-file write port.

Function
REQ-011 The block SHALL contain a one-entry LU holding buffer (hold_bus, 38 bits) and a 3-bit starvation counter starve_cnt.
REQ-012 FSM states SHALL be EMPTY (buffer empty), HELD (buffer full, WB has priority) and FORCE (buffer full, LU has priority).
REQ-013 LU handshake: lu_valid && lu_ready loads lu_bus into hold_bus; EMPTY->HELD next cycle.
REQ-014 EMPTY/HELD: wb_ready=1; a granted WB request drives rf_bus next cycle.
REQ-015 HELD with wb_valid=0: LU entry granted; rf_bus=hold_bus next cycle; HELD->EMPTY; starve_cnt cleared.
REQ-016 HELD with wb_valid=1: starve_cnt increments; when starve_cnt reaches STARVE_MAX-1 on a denial, HELD->FORCE.
REQ-017 FORCE: wb_ready=0; LU entry granted; FORCE->EMPTY; starve_cnt cleared.
REQ-018 WAW: in HELD, a granted WB request with we=1 and waddr equal to the held nonzero waddr SHALL discard the held entry (HELD->EMPTY, starve_cnt cleared) in the same cycle.
REQ-019 Any granted write with waddr=0 SHALL appear on rf_bus with we forced to 0.
REQ-020 With no grant in a cycle, rf_bus.we SHALL be 0 next cycle; waddr/wdata hold their previous values.
REQ-021 Latency: exactly 1 cycle from grant to rf_bus; at most one write per cycle.
REQ-022 A WB request that is not granted (FORCE) SHALL be held stable by the requester; the block does not capture it.
REQ-023 lu_valid while lu_ready=0 SHALL be ignored (no capture, no state change).

Reset
REQ-024 While reset=0 at a posedge: state=EMPTY, hold_bus=0, starve_cnt=0, rf_bus=0; any held LU entry is lost.
REQ-025 Out of reset, lu_ready=1 and wb_ready=1 in the first cycle.

Configuration
REQ-026 Macro RF_WB_ARBITER_PERF_EN: when defined, adds outputs perf_wb_stall (32, count of cycles with wb_valid=1 && wb_ready=0) and perf_lu_drop (32, count of WAW discards), both saturating at 0xFFFFFFFF and cleared by reset.
REQ-027 When RF_WB_ARBITER_PERF_EN is undefined, those ports and counters SHALL NOT exist; all other behaviour identical.

Verification
REQ-028 WB only: wb_bus={1,5'd3,32'h1234} valid 1 cycle -> next cycle rf_bus={1,3,0x1234}, wb_ready=1 throughout.
REQ-029 LU idle pipeline: lu_bus={1,7,0xAA} with wb_valid=0 -> captured, rf_bus={1,7,0xAA} two cycles after handshake, lu_ready returns 1.
REQ-030 Starvation, STARVE_MAX=4: LU held, wb_valid=1 continuously -> 4 WB writes, then wb_ready=0 for 1 cycle and rf_bus carries the LU entry.
REQ-031 WAW: held LU {1,9,0x1}, WB {1,9,0x2} granted -> rf_bus={1,9,0x2}, LU entry never written, state EMPTY (perf_lu_drop=1 when PERF_EN).
REQ-032 r0 and reset: WB {1,0,0xFF} -> rf_bus.we=0; reset asserted in HELD -> next cycle state EMPTY, rf_bus=0, lu_ready=1.
